// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants shared by the timing generator and
// every block that draws inside the visible window.
package vga_timing_pkg;

  localparam int CLK_DIV_DEF     = 4;
  localparam int H_TOTAL_DEF     = 800;
  localparam int V_TOTAL_DEF     = 525;
  localparam int H_SYNC_DEF      = 96;
  localparam int V_SYNC_DEF      = 2;
  localparam int H_ACT_START_DEF = 144;
  localparam int H_ACT_END_DEF   = 784;
  localparam int V_ACT_START_DEF = 35;
  localparam int V_ACT_END_DEF   = 515;

  typedef logic [9:0] coord_t;

  // Half-open interval test lo <= x < hi.
  function automatic logic in_span(input int x, input int lo, input int hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/pixel_clk_en.sv
// Divides the system clock into a one-cycle pixel enable every CLK_DIV clocks.
module pixel_clk_en #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic srst,
  output logic pix_en
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      div_reg <= '0;
    end else if (div_reg == DIV_LAST) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  assign pix_en = (div_reg == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel coordinates, sync/blanking decode, and frame-derived
// ticks used as clock enables by the game logic.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int H_ACT_END   = H_ACT_END_DEF,
  parameter int V_ACT_START = V_ACT_START_DEF,
  parameter int V_ACT_END   = V_ACT_END_DEF,
  parameter int MOVE_DIV    = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       pix_en,
  output logic       frame_tick,
  output logic       move_tick
);

  localparam coord_t H_LAST = 10'(H_TOTAL - 1);
  localparam coord_t V_LAST = 10'(V_TOTAL - 1);
  localparam int FW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(MOVE_DIV - 1);

  coord_t        h_count_reg, h_count_next;
  coord_t        v_count_reg, v_count_next;
  logic          bright_reg, hsync_reg, vsync_reg;
  logic          frame_tick_reg, move_tick_reg;
  logic [FW-1:0] fcnt_reg;
  logic          frame_wrap;

  pixel_clk_en #(.CLK_DIV(CLK_DIV)) u_pixel_clk_en (
    .clk    (clk),
    .srst   (rst),
    .pix_en (pix_en)
  );

  always_comb begin
    h_count_next = h_count_reg;
    v_count_next = v_count_reg;
    frame_wrap   = 1'b0;
    if (pix_en) begin
      if (h_count_reg == H_LAST) begin
        h_count_next = '0;
        if (v_count_reg == V_LAST) begin
          v_count_next = '0;
          frame_wrap   = 1'b1;
        end else begin
          v_count_next = v_count_reg + 1'b1;
        end
      end else begin
        h_count_next = h_count_reg + 1'b1;
      end
    end
  end

  // Decodes use the next counter values so they line up with the coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_count_reg    <= '0;
      v_count_reg    <= '0;
      bright_reg     <= 1'b0;
      hsync_reg      <= 1'b0;
      vsync_reg      <= 1'b0;
      frame_tick_reg <= 1'b0;
      move_tick_reg  <= 1'b0;
      fcnt_reg       <= '0;
    end else begin
      h_count_reg    <= h_count_next;
      v_count_reg    <= v_count_next;
      bright_reg     <= in_span(int'(h_count_next), H_ACT_START, H_ACT_END) &&
                        in_span(int'(v_count_next), V_ACT_START, V_ACT_END);
      hsync_reg      <= (int'(h_count_next) >= H_SYNC);
      vsync_reg      <= (int'(v_count_next) >= V_SYNC);
      frame_tick_reg <= frame_wrap;
      move_tick_reg  <= frame_wrap && (fcnt_reg == F_LAST);
      if (frame_wrap) begin
        fcnt_reg <= (fcnt_reg == F_LAST) ? '0 : fcnt_reg + 1'b1;
      end
    end
  end

  assign hCount     = h_count_reg;
  assign vCount     = v_count_reg;
  assign bright     = bright_reg;
  assign hSync      = hsync_reg;
  assign vSync      = vsync_reg;
  assign frame_tick = frame_tick_reg;
  assign move_tick  = move_tick_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed checks: instance a uses the default 640x480 timing for line-level
// behaviour, instance b uses a tiny raster so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [9:0] a_h, a_v, b_h, b_v;
  logic       a_bright, a_hs, a_vs, a_pix, a_ft, a_mt;
  logic       b_bright, b_hs, b_vs, b_pix, b_ft, b_mt;

  int checks = 0;
  int errors = 0;
  int stray  = 0;
  int wide   = 0;
  int n;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .hCount(a_h), .vCount(a_v), .bright(a_bright),
    .hSync(a_hs), .vSync(a_vs), .pix_en(a_pix), .frame_tick(a_ft), .move_tick(a_mt)
  );

  // 16x10 raster, 2 clks per pixel: one frame is 320 clks.
  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(16), .V_TOTAL(10), .H_SYNC(3), .V_SYNC(2),
    .H_ACT_START(5), .H_ACT_END(13), .V_ACT_START(3), .V_ACT_END(8), .MOVE_DIV(3)
  ) dut_b (
    .clk(clk), .rst(rst_b), .hCount(b_h), .vCount(b_v), .bright(b_bright),
    .hSync(b_hs), .vSync(b_vs), .pix_en(b_pix), .frame_tick(b_ft), .move_tick(b_mt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cnt);
    repeat (cnt) @(negedge clk);
  endtask

  task automatic wait_at(input bit sel, input int h, input int v, input int budget,
                         input string tag);
    int k;
    logic hit;
    k = 0;
    hit = sel ? (int'(b_h) == h && int'(b_v) == v) : (int'(a_h) == h && int'(a_v) == v);
    while (!hit && k < budget) begin
      tick(1);
      k++;
      hit = sel ? (int'(b_h) == h && int'(b_v) == v) : (int'(a_h) == h && int'(a_v) == v);
    end
    chk({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  // Clocks until the next frame_tick on instance b; tracks stray move ticks.
  task automatic wait_ft(output int cnt);
    cnt = 0;
    do begin
      tick(1);
      cnt++;
      if (b_mt && !b_ft) stray++;
      if (cnt == 1 && b_ft) wide++;
    end while (!b_ft && cnt < 1000);
  endtask

  task automatic wait_pix(input bit sel);
    int k;
    k = 0;
    while (!(sel ? b_pix : a_pix) && k < 8) begin
      tick(1);
      k++;
    end
    chk("pix_en_seen", 32'(sel ? b_pix : a_pix), 32'd1);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick(3);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick(1001);

    // Reset held two clocks at arbitrary counter values
    rst_a = 1'b1;
    tick(2);
    rst_a = 1'b0;
    chk("rst_hCount", 32'(a_h), 32'd0);
    chk("rst_vCount", 32'(a_v), 32'd0);
    chk("rst_hSync", 32'(a_hs), 32'd0);
    chk("rst_vSync", 32'(a_vs), 32'd0);
    chk("rst_bright", 32'(a_bright), 32'd0);
    chk("rst_ticks", 32'({a_ft, a_mt}), 32'd0);
    n = 1;
    while (!a_pix && n < 10) begin
      tick(1);
      n++;
    end
    chk("first_pix_en_cycle", 32'(n), 32'd4);
    tick(1);
    chk("hCount_after_first_pix", 32'(a_h), 32'd1);
    chk("pix_en_one_clk", 32'(a_pix), 32'd0);

    wait_at(1'b0, 95, 0, 400, "a_95");
    chk("hSync_at_95", 32'(a_hs), 32'd0);
    wait_at(1'b0, 96, 0, 20, "a_96");
    chk("hSync_at_96", 32'(a_hs), 32'd1);
    wait_at(1'b0, 0, 1, 3300, "a_v1");
    chk("vSync_at_v1", 32'(a_vs), 32'd0);
    wait_at(1'b0, 0, 2, 3300, "a_v2");
    chk("vSync_at_v2", 32'(a_vs), 32'd1);

    // Line wrap
    wait_at(1'b0, 799, 10, 30000, "a_799_10");
    chk("bright_799_10", 32'(a_bright), 32'd0);
    wait_pix(1'b0);
    tick(1);
    chk("wrap_hCount", 32'(a_h), 32'd0);
    chk("wrap_vCount", 32'(a_v), 32'd11);
    chk("wrap_hSync", 32'(a_hs), 32'd0);

    // Window edges on the small raster
    rst_b = 1'b1;
    tick(1);
    rst_b = 1'b0;
    wait_at(1'b1, 5, 2, 400, "b_5_2");
    chk("bright_5_2", 32'(b_bright), 32'd0);
    wait_at(1'b1, 4, 3, 400, "b_4_3");
    chk("bright_4_3", 32'(b_bright), 32'd0);
    wait_at(1'b1, 5, 3, 400, "b_5_3");
    chk("bright_5_3", 32'(b_bright), 32'd1);
    wait_at(1'b1, 12, 7, 400, "b_12_7");
    chk("bright_12_7", 32'(b_bright), 32'd1);
    wait_at(1'b1, 13, 7, 400, "b_13_7");
    chk("bright_13_7", 32'(b_bright), 32'd0);
    wait_at(1'b1, 8, 8, 400, "b_8_8");
    chk("bright_8_8", 32'(b_bright), 32'd0);

    // Frame period and move divider over ten frames
    rst_b = 1'b1;
    tick(1);
    rst_b = 1'b0;
    wait_ft(n);
    chk("first_frame_tick_clks", 32'(n), 32'd320);
    chk("frame_tick_h", 32'(b_h), 32'd0);
    chk("frame_tick_v", 32'(b_v), 32'd0);
    chk("move_frame1", 32'(b_mt), 32'd0);
    for (int f = 2; f <= 10; f++) begin
      wait_ft(n);
      chk($sformatf("frame%0d_period", f), 32'(n), 32'd320);
      chk($sformatf("move_frame%0d", f), 32'(b_mt), 32'((f % 3) == 0));
    end

    // Reset coincident with pix_en mid-frame, divider mid-count
    wait_at(1'b1, 9, 6, 400, "b_9_6");
    wait_pix(1'b1);
    rst_b = 1'b1;
    tick(1);
    rst_b = 1'b0;
    chk("midrst_hCount", 32'(b_h), 32'd0);
    chk("midrst_vCount", 32'(b_v), 32'd0);
    chk("midrst_ticks", 32'({b_ft, b_mt, b_pix}), 32'd0);
    for (int f = 1; f <= 3; f++) begin
      wait_ft(n);
      chk($sformatf("post_rst_frame%0d_period", f), 32'(n), 32'd320);
      chk($sformatf("post_rst_move%0d", f), 32'(b_mt), 32'(f == 3));
    end
    chk("stray_move_ticks", 32'(stray), 32'd0);
    chk("frame_tick_width", 32'(wide), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Produces the 640x480@60 Hz raster timing that `block_controller` consumes: `hCount`/`vCount` pixel coordinates, `bright`, and active-low `hSync`/`vSync` for the Nexys-4 VGA port. It also supplies the game's motion clock enable (`move_tick`), derived from frame boundaries. It sits at the top level between the 100 MHz board clock and every pixel-rendering block.

## Interface
Parameters:
- `CLK_DIV`, default 4: system clocks per pixel. 100 MHz / 4 = 25 MHz. Must be ≥ 2.
- `H_TOTAL`, default 800: pixels per line.
- `V_TOTAL`, default 525: lines per frame.
- `H_SYNC`, default 96: `hSync` is low while `hCount` < `H_SYNC`.
- `V_SYNC`, default 2: `vSync` is low while `vCount` < `V_SYNC`.
- `H_ACT_START`, default 144: first visible column.
- `H_ACT_END`, default 784: first column after the visible region.
- `V_ACT_START`, default 35: first visible line.
- `V_ACT_END`, default 515: first line after the visible region.
- `MOVE_DIV`, default 1: frames per `move_tick`. Must be ≥ 1.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `hCount`  out  10  current column, 0..H_TOTAL-1.
- `vCount`  out  10  current line, 0..V_TOTAL-1.
- `bright`  out  1  high inside the visible window.
- `hSync`  out  1  horizontal sync, active low.
- `vSync`  out  1  vertical sync, active low.
- `pix_en`  out  1  one-`clk` pulse per pixel period.
- `frame_tick`  out  1  one-`clk` pulse at the start of each frame.
- `move_tick`  out  1  one-`clk` pulse every `MOVE_DIV` frames.

## Operation
Pixel divider:
- Counter `div` runs 0..CLK_DIV-1, wraps, and advances every `clk`.
- `pix_en` = 1 in the cycle where `div` == CLK_DIV-1.

Raster counters (update only on `pix_en`):
- `hCount` increments. At H_TOTAL-1 it wraps to 0 and `vCount` increments.
- `vCount` wraps from V_TOTAL-1 to 0 when `hCount` wraps.

Decoded outputs (registered, computed from the next counter values so they align with the `hCount`/`vCount` they describe):
- `bright` = (H_ACT_START ≤ hCount < H_ACT_END) && (V_ACT_START ≤ vCount < V_ACT_END).
- `hSync` = (hCount ≥ H_SYNC).
- `vSync` = (vCount ≥ V_SYNC).

Frame and move ticks:
- `frame_tick` = 1 for exactly the `clk` cycle in which the counters first show (0,0) after wrapping from (H_TOTAL-1, V_TOTAL-1).
- Frame counter `fcnt` runs 0..MOVE_DIV-1 and increments on `frame_tick`.
- `move_tick` = `frame_tick` && (fcnt == MOVE_DIV-1), then `fcnt` returns to 0.

Reset values:
- Internal counters: `div`=0, `fcnt`=0.
- Outputs: `hCount`=0, `vCount`=0, `bright`=0, `hSync`=0 (column 0 is inside the sync pulse), `vSync`=0, `pix_en`=0, `frame_tick`=0, `move_tick`=0.
- No `frame_tick` is issued for the post-reset (0,0). The first tick comes after one full frame.

Boundary conditions:
- `rst` mid-line or mid-frame: the next cycle restores all reset values. No tick or partial pulse is emitted.
- `rst` coincident with `pix_en` or with a wrap: `rst` wins.
- `MOVE_DIV`=1: `move_tick` equals `frame_tick`.

## Timing
- Clock periods from the end of reset:
  - `pix_en` period: CLK_DIV.
  - Line: H_TOTAL·CLK_DIV = 3200 clks.
  - Frame: 3200·525 = 1,680,000 clks.
- Latency: the first `pix_en` occurs CLK_DIV clks after `rst` deasserts. `hCount`=1 is visible the cycle after that.
- All outputs change only on the cycle following `pix_en`, except `pix_en` itself.
- `frame_tick` and `move_tick` last one `clk`, not one pixel.
- Downstream blocks must use them as enables, not as clocks.

## Structure
- Package `vga_timing_pkg` holds the default timing constants (H/V totals, sync widths, active-window bounds). `block_controller` shares the window bounds, e.g. ground line 515.
- One sub-module: `pixel_clk_en`, the CLK_DIV counter that generates `pix_en`.
- Raster counters, decoders and frame/move logic live in the top of this block.

## Test plan
- Reset: hold `rst` 2 clks at arbitrary counter values, release → `hCount`=0, `vCount`=0, `hSync`=0, `vSync`=0, `bright`=0; first `pix_en` exactly 4 clks later.
- Line wrap: run to `hCount`=799, `vCount`=10 → after next `pix_en`, `hCount`=0, `vCount`=11. `hSync` rises at `hCount`=96.
- Window edges: `bright`=0 at (143,35), 1 at (144,35), 1 at (783,514), 0 at (784,514), 0 at (200,515).
- Frame: `frame_tick` first pulses 1,680,000 clks after reset release, lasting 1 clk. `vSync` is low only for `vCount` 0..1.
- Move divider: with `MOVE_DIV`=3, `move_tick` coincides with every 3rd `frame_tick` (frames 3, 6, 9) and never otherwise.
- Mid-frame reset: assert `rst` at (400,300) → next cycle counters are (0,0); no `frame_tick` or `move_tick` until a full frame later.
